// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: one outstanding SRAM-like request, held output to decode
// Optional misaligned-fetch reporting (id_adel_o) is built only when IF_ADDR_ERR_EN is defined.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_en_o,
  input  logic              flush_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
`ifdef IF_ADDR_ERR_EN
  output logic              id_adel_o,
`endif
  output logic [DATA_W-1:0] id_inst_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t            state, state_n;
  logic              drop, drop_n;
  logic [ADDR_W-1:0] req_pc, req_pc_n;
  logic              valid_q, valid_n;
  logic [ADDR_W-1:0] out_pc_q, out_pc_n;
  logic [DATA_W-1:0] out_inst_q, out_inst_n;
  logic              addr_err;

`ifdef IF_ADDR_ERR_EN
  logic              adel_q, adel_n;
  assign addr_err  = (pc_i[1:0] != 2'b00);
  assign id_adel_o = adel_q;
`else
  assign addr_err  = 1'b0;
`endif

  assign inst_addr  = pc_i;
  assign id_valid_o = valid_q;
  assign id_pc_o    = out_pc_q;
  assign id_inst_o  = out_inst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      drop       <= 1'b0;
      req_pc     <= '0;
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
`ifdef IF_ADDR_ERR_EN
      adel_q     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      drop       <= drop_n;
      req_pc     <= req_pc_n;
      valid_q    <= valid_n;
      out_pc_q   <= out_pc_n;
      out_inst_q <= out_inst_n;
`ifdef IF_ADDR_ERR_EN
      adel_q     <= adel_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    drop_n     = drop;
    req_pc_n   = req_pc;
    valid_n    = valid_q;
    out_pc_n   = out_pc_q;
    out_inst_n = out_inst_q;
    inst_req   = 1'b0;
    pc_en_o    = 1'b0;
`ifdef IF_ADDR_ERR_EN
    adel_n     = adel_q;
`endif

    case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end

      S_REQ: begin
        if (addr_err) begin
          // Misaligned PC never reaches memory; report it as a held pseudo-instruction.
          pc_en_o = 1'b1;
          drop_n  = 1'b0;
          if (!flush_i) begin
            state_n    = S_HOLD;
            valid_n    = 1'b1;
            out_pc_n   = pc_i;
            out_inst_n = '0;
`ifdef IF_ADDR_ERR_EN
            adel_n     = 1'b1;
`endif
          end
        end else begin
          inst_req = 1'b1;
          if (inst_addr_ok) begin
            pc_en_o  = 1'b1;
            req_pc_n = pc_i;
            if (drop || flush_i) begin
              state_n = S_DISCARD;
              drop_n  = 1'b0;
            end else begin
              state_n = S_WAIT;
            end
          end else if (flush_i) begin
            // The request cannot be retracted, so remember to throw its data away.
            drop_n = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (inst_data_ok) begin
          if (flush_i) begin
            state_n = S_REQ;
          end else begin
            state_n    = S_HOLD;
            valid_n    = 1'b1;
            out_pc_n   = req_pc;
            out_inst_n = inst_rdata;
          end
        end else if (flush_i) begin
          state_n = S_DISCARD;
        end
      end

      S_HOLD: begin
        if (flush_i || id_ready_i) begin
          state_n = S_REQ;
          valid_n = 1'b0;
`ifdef IF_ADDR_ERR_EN
          adel_n  = 1'b0;
`endif
        end
      end

      S_DISCARD: begin
        if (inst_data_ok) begin
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed scoreboard bench for if_fetch
module tb_if_fetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_en_o;
  logic              flush_i;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
`ifdef IF_ADDR_ERR_EN
  logic              id_adel_o;
`endif

  if_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_en_o      (pc_en_o),
    .flush_i      (flush_i),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
`ifdef IF_ADDR_ERR_EN
    .id_adel_o    (id_adel_o),
`endif
    .id_inst_o    (id_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              adel;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] inst, input logic adel);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.adel = adel;
    exp_q.push_back(e);
  endtask

  // Monitor: any valid output must match the oldest expected entry; pop on handshake.
  always @(negedge clk) begin
    if (rst && id_valid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {32'h0, id_pc_o}, 64'hffff_ffff_ffff_ffff);
      end else if (id_ready_i) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", {32'h0, id_pc_o}, {32'h0, e.pc});
        check("out_inst", {32'h0, id_inst_o}, {32'h0, e.inst});
`ifdef IF_ADDR_ERR_EN
        check("out_adel", {63'h0, id_adel_o}, {63'h0, e.adel});
`endif
      end
    end
  end

  initial begin
    rst          = 1'b0;
    pc_i         = 32'hbfc0_0000;
    flush_i      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    id_ready_i   = 1'b1;

    tick();
    tick();
    @(negedge clk);
    check("rst_inst_req", {63'h0, inst_req}, 64'h0);
    check("rst_pc_en", {63'h0, pc_en_o}, 64'h0);
    check("rst_valid", {63'h0, id_valid_o}, 64'h0);
    check("rst_id_pc", {32'h0, id_pc_o}, 64'h0);
    check("rst_id_inst", {32'h0, id_inst_o}, 64'h0);

    // Basic fetch: addr_ok immediately, data two cycles later.
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_req", {63'h0, inst_req}, 64'h0);
    tick();
    inst_addr_ok = 1'b1;
    push(32'hbfc0_0000, 32'h2401_0001, 1'b0);
    @(negedge clk);
    check("t1_req", {63'h0, inst_req}, 64'h1);
    check("t1_addr", {32'h0, inst_addr}, {32'h0, 32'hbfc0_0000});
    check("t1_pc_en", {63'h0, pc_en_o}, 64'h1);
    tick();
    inst_addr_ok = 1'b0;
    pc_i         = 32'hbfc0_0004;
    @(negedge clk);
    check("t1_wait_no_req", {63'h0, inst_req}, 64'h0);
    check("t1_pc_en_once", {63'h0, pc_en_o}, 64'h0);
    tick();
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h2401_0001;
    @(negedge clk);
    check("t1_no_valid_yet", {63'h0, id_valid_o}, 64'h0);
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    @(negedge clk);
    check("t1_valid", {63'h0, id_valid_o}, 64'h1);
    tick();
    @(negedge clk);
    check("t1_next_req", {63'h0, inst_req}, 64'h1);

    // Decode stalls for five cycles in HOLD.
    id_ready_i   = 1'b0;
    inst_addr_ok = 1'b1;
    push(32'hbfc0_0004, 32'h8c02_0004, 1'b0);
    tick();
    inst_addr_ok = 1'b0;
    pc_i         = 32'hbfc0_0008;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h8c02_0004;
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {63'h0, id_valid_o}, 64'h1);
      check("stall_pc", {32'h0, id_pc_o}, {32'h0, 32'hbfc0_0004});
      check("stall_inst", {32'h0, id_inst_o}, {32'h0, 32'h8c02_0004});
      check("stall_no_req", {63'h0, inst_req}, 64'h0);
      tick();
    end
    id_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("stall_req_after", {63'h0, inst_req}, 64'h1);
    check("stall_valid_clr", {63'h0, id_valid_o}, 64'h0);

    // Flush while waiting for data: stale word must be dropped.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    flush_i      = 1'b1;
    pc_i         = 32'h8000_0100;
    tick();
    flush_i      = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hdead_beef;
    @(negedge clk);
    check("wflush_no_req", {63'h0, inst_req}, 64'h0);
    tick();
    inst_data_ok = 1'b0;
    @(negedge clk);
    check("wflush_req", {63'h0, inst_req}, 64'h1);
    check("wflush_addr", {32'h0, inst_addr}, {32'h0, 32'h8000_0100});
    check("wflush_no_valid", {63'h0, id_valid_o}, 64'h0);
    inst_addr_ok = 1'b1;
    push(32'h8000_0100, 32'h3c1d_8000, 1'b0);
    tick();
    inst_addr_ok = 1'b0;
    pc_i         = 32'h8000_0104;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h3c1d_8000;
    tick();
    inst_data_ok = 1'b0;
    tick();

    // Flush in REQ while memory withholds addr_ok for three cycles.
    flush_i = 1'b1;
    @(negedge clk);
    check("rflush_req0", {63'h0, inst_req}, 64'h1);
    tick();
    flush_i = 1'b0;
    pc_i    = 32'h8000_0200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rflush_req_held", {63'h0, inst_req}, 64'h1);
      tick();
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    check("rflush_stale_pc_en", {63'h0, pc_en_o}, 64'h1);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hdead_beef;
    @(negedge clk);
    check("rflush_disc_no_req", {63'h0, inst_req}, 64'h0);
    tick();
    inst_data_ok = 1'b0;
    @(negedge clk);
    check("rflush_req_new", {63'h0, inst_req}, 64'h1);
    check("rflush_addr_new", {32'h0, inst_addr}, {32'h0, 32'h8000_0200});
    check("rflush_no_valid", {63'h0, id_valid_o}, 64'h0);

    // Flush coincident with data_ok in WAIT.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    flush_i      = 1'b1;
    pc_i         = 32'h8000_0300;
    tick();
    inst_data_ok = 1'b0;
    flush_i      = 1'b0;
    @(negedge clk);
    check("cflush_req", {63'h0, inst_req}, 64'h1);
    check("cflush_no_valid", {63'h0, id_valid_o}, 64'h0);

    // Recovery fetch after all flushes.
    inst_addr_ok = 1'b1;
    push(32'h8000_0300, 32'h0000_000c, 1'b0);
    tick();
    inst_addr_ok = 1'b0;
    pc_i         = 32'h8000_0304;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h0000_000c;
    tick();
    inst_data_ok = 1'b0;
    tick();

`ifdef IF_ADDR_ERR_EN
    pc_i = 32'hbfc0_0002;
    push(32'hbfc0_0002, 32'h0, 1'b1);
    @(negedge clk);
    check("adel_no_req", {63'h0, inst_req}, 64'h0);
    check("adel_pc_en", {63'h0, pc_en_o}, 64'h1);
    tick();
    pc_i = 32'hbfc0_0004;
    @(negedge clk);
    check("adel_valid", {63'h0, id_valid_o}, 64'h1);
    check("adel_flag", {63'h0, id_adel_o}, 64'h1);
    tick();
    @(negedge clk);
    check("adel_clear", {63'h0, id_adel_o}, 64'h0);
`endif

    // Reset in the middle of a transaction.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    rst          = 1'b0;
    #1;
    check("mid_rst_req", {63'h0, inst_req}, 64'h0);
    check("mid_rst_valid", {63'h0, id_valid_o}, 64'h0);
    check("mid_rst_id_pc", {32'h0, id_pc_o}, 64'h0);

    tick();
    check("queue_drained", {32'h0, exp_q.size()}, 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage between the PC register and the decode stage. Takes the current PC and issues one request at a time on the SRAM-like instruction-memory interface. It pulses the PC-advance enable when the address is accepted, and holds each returned instruction with its PC in an output register until decode accepts it. A flush (branch redirect or exception) discards any in-flight fetch.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_i  in  ADDR_W  current PC from PC register
- pc_en_o  out  1  advance PC register; combinational, equals inst_req & inst_addr_ok
- flush_i  in  1  discard in-flight fetch and held output
- inst_req  out  1  memory request valid
- inst_addr  out  ADDR_W  request address; equals pc_i while inst_req
- inst_addr_ok  in  1  address accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  DATA_W  read data
- id_valid_o  out  1  instruction valid to decode
- id_ready_i  in  1  decode accepts this cycle
- id_pc_o  out  ADDR_W  PC of held instruction
- id_inst_o  out  DATA_W  held instruction
- id_adel_o  out  1  fetch address error; port exists only with IF_ADDR_ERR_EN

## Operation
- At most one outstanding request.
- States and transitions:
  - IDLE → REQ one cycle after rst deasserts.
  - REQ: inst_req=1.
    - On inst_addr_ok: latch pc_i into req_pc. Go to DISCARD if the drop flag is set or flush_i=1; otherwise go to WAIT.
    - flush_i without inst_addr_ok sets the drop flag. The request stays asserted, because the protocol forbids retracting it.
  - WAIT: on inst_data_ok, load id_inst_o←inst_rdata, id_pc_o←req_pc, set id_valid_o, and go to HOLD. If flush_i is high in the same cycle, drop the data and go to REQ.
  - HOLD: id_valid_o=1. On id_ready_i or flush_i, clear id_valid_o and go to REQ. Flush has priority.
  - DISCARD: wait for inst_data_ok, ignore the data, clear the drop flag, go to REQ. flush_i here has no additional effect.
- The drop flag is cleared on entry to DISCARD.
- pc_en_o pulses on every address acceptance, including stale ones. The PC register then applies its saved redirect target.
- id_pc_o and id_inst_o are stable while id_valid_o=1 and id_ready_i=0.

## Timing
- Reset values:
  - state IDLE; inst_req 0; pc_en_o 0; id_valid_o 0
  - id_pc_o 0; id_inst_o 0; drop flag 0; id_adel_o 0
- Address handshake at cycle T:
  - data_ok is legal from T+1.
  - With data_ok at cycle D, id_valid_o is high from D+1.
- Same-cycle addr_ok and data_ok in REQ is illegal memory behaviour and is not handled.
- After a HOLD handshake in cycle H, inst_req is high in H+1.
- Maximum throughput is one instruction per 3 cycles.
- Reset mid-transaction returns all state to reset values immediately. The memory side is reset by the same rst.

## Configuration
- IF_ADDR_ERR_EN defined:
  - In REQ, if pc_i[1:0]≠0, inst_req stays 0.
  - pc_en_o is forced to 1 for one cycle.
  - Next cycle: id_valid_o=1, id_adel_o=1, id_pc_o=pc_i, id_inst_o=0, state HOLD.
  - id_adel_o clears when HOLD exits.
- IF_ADDR_ERR_EN undefined:
  - No id_adel_o port.
  - Misaligned pc_i is issued to memory unchanged.

## Test plan
- Reset release, pc_i=0xbfc00000, addr_ok immediate, data_ok 2 cycles later with 0x24010001, id_ready=1 → one pc_en_o pulse; id_valid_o with id_pc_o=0xbfc00000, id_inst_o=0x24010001; next inst_req after handshake.
- id_ready_i=0 for 5 cycles in HOLD → outputs stable, no inst_req; ready=1 → inst_req next cycle.
- flush_i during WAIT, stale data 0xdeadbeef returns → id_valid_o never asserts for it; new request follows with pc_i=redirect target.
- flush_i in REQ while addr_ok held low 3 cycles → inst_req stays high; on accept go to DISCARD; returned data dropped; next request issued.
- flush_i and inst_data_ok same cycle in WAIT → no id_valid_o; state REQ next cycle.
- (IF_ADDR_ERR_EN) pc_i=0xbfc00002 → no inst_req, pc_en_o pulse, id_valid_o=1 with id_adel_o=1, id_pc_o=0xbfc00002.
